// File: rtl/sb_stream_fifo.sv
// First-word-fall-through FIFO for the switchboard stream (data/dest/last, valid/ready).
// Define SB_STREAM_FIFO_PKT_MODE_EN to hold each packet back until its last beat is stored.
module sb_stream_fifo #(
  parameter int DW    = 416,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int EW = DW + 33;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // MSB of each pointer is a wrap bit, so equal indices disambiguate full from empty
  always_comb begin
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    empty    = (wr_ptr == rd_ptr);
    level    = wr_ptr - rd_ptr;
    in_ready = !full;
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_dest, in_data};
  end

  always_comb begin
    head = mem[rd_ptr[AW-1:0]];
  end

  always_comb begin
    out_data = '0;
    out_dest = '0;
    out_last = 1'b0;
    if (out_valid) {out_last, out_dest, out_data} = head;
  end

`ifdef SB_STREAM_FIFO_PKT_MODE_EN
  logic [AW:0] pkt_cnt;
  logic        pkt_in;
  logic        pkt_out;

  always_comb begin
    pkt_in  = push && in_last;
    pkt_out = pop && out_last;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Full releases the head regardless, so packets longer than DEPTH stream cut-through
  always_comb begin
    out_valid = !empty && ((pkt_cnt != '0) || full);
  end
`else
  always_comb begin
    out_valid = !empty;
  end
`endif

endmodule

// File: doc/sb_stream_fifo.md
Name: sb_stream_fifo

Overview:
- Synchronous first-word-fall-through FIFO for the switchboard stream (data/dest/last with valid/ready).
- Sits directly downstream of the queue-to-switchboard receive stage and decouples its bursty valid pattern from the consuming logic.
- Every beat is stored with its dest and last.
- Optional store-and-forward mode releases a packet only once it is complete.

Parameters:
- DW, 416, data width in bits; any value ≥ 1.
- DEPTH, 4, number of entries; power of two, ≥ 2.
- Derived localparam AW = $clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_data  input  DW  incoming beat data.
- in_dest  input  32  incoming beat destination.
- in_last  input  1  incoming beat is the final beat of its packet.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  FIFO can accept a beat.
- out_data  output  DW  head-of-FIFO data.
- out_dest  output  32  head-of-FIFO destination.
- out_last  output  1  head-of-FIFO last flag.
- out_valid  output  1  head beat presented.
- out_ready  input  1  downstream accepts the head beat.
- level  output  AW+1  number of stored beats, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Storage: DEPTH entries of {last, dest[31:0], data[DW-1:0]}. Storage is not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits wide; the MSB is the wrap bit.
  - level = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - full when the indices are equal and the wrap bits differ.
  - empty when the pointers are equal.
- Reset (nreset low, asynchronous):
  - wr_ptr = rd_ptr = 0 immediately.
  - Outputs: in_ready=1, out_valid=0, level=0, empty=1, full=0; out_data, out_dest and out_last are 0.
  - A reset asserted mid-packet discards all stored beats, including partial packets. No beat is presented until new pushes occur after release.
- Handshake:
  - in_ready = !full. A push occurs when in_valid & in_ready; it writes the entry at wr_ptr and increments wr_ptr.
  - A pop occurs when out_valid & out_ready; it increments rd_ptr.
  - in_valid and in_data must be held stable until accepted. out_valid must never drop without a pop, except on reset.
- Latency:
  - A beat pushed at edge N is visible on the outputs after edge N (base mode). There is no combinational bypass: an empty FIFO never shows in_* on out_*.
  - Throughput is 1 beat/cycle sustained when out_ready=1.
- Outputs: out_data, out_dest and out_last read the entry at rd_ptr combinationally, and are forced to 0 whenever out_valid=0.
- Simultaneous push and pop:
  - Allowed at any level from 1 to DEPTH-1; level is unchanged.
  - When full, in_ready=0, so a same-cycle pop does not admit a push. The push lands the following cycle.
  - When empty, no pop is possible.
- Wrap-around: index bits wrap modulo DEPTH. Beat order is strictly preserved across any number of wraps.
- Arithmetic: all pointer math is modulo 2^(AW+1), with no saturation.

Optional Feature:
SB_STREAM_FIFO_PKT_MODE_EN
- Defined:
  - Adds a pkt_cnt counter, AW+1 bits, reset to 0.
  - pkt_cnt increments on a push with in_last=1 and decrements on a pop with out_last=1. Both in the same cycle leave it unchanged.
  - out_valid = !empty && ((pkt_cnt != 0) || full). The full term is a deadlock escape: a packet longer than DEPTH streams through cut-through once the FIFO fills.
  - A beat written with in_last=1 at edge N releases its packet on out_valid after edge N.
- Undefined: pkt_cnt is absent and out_valid = !empty.

Test Plan:
- Reset mid-stream: push 3 beats, assert nreset low for 1 cycle (asynchronous, between edges) → immediately level=0, empty=1, out_valid=0, in_ready=1, out_data=0; the next pushed beat 0xAA is the first popped.
- Fill with DEPTH=4 and out_ready=0: push data 1,2,3,4 → after the 4th edge full=1, level=4, in_ready=0. A 5th beat (data 5) is held. Raise out_ready for 1 cycle → pops 1, level=3, then beat 5 is accepted on the next edge.
- Simultaneous push/pop at level 2 for 5 cycles → level stays 2 and the output order matches the input order exactly.
- Streaming with out_ready=in_valid=1: push data 0..9 with dest=0x100+i and last on i=4 and i=9 → output 0..9 back-to-back after 1 cycle latency. Pointers wrap twice; dest and last are preserved per beat.
- PKT_MODE: push 3 beats with last=0,0,1 on consecutive cycles → out_valid stays 0 until after the edge that writes the last beat, then 3 beats pop consecutively. Without the macro, out_valid rises after the first push edge.
- PKT_MODE deadlock escape: push 4 beats, all last=0, with DEPTH=4 → out_valid=1 once full=1. Popping 1 beat drops out_valid (not full, pkt_cnt=0) until a last beat arrives or the FIFO refills.
